// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic inter-stage register with a two-entry skid buffer,
// ageing Tnew and a synchronous hazard-safe flush.
module pipe_stage_reg #(
   parameter int DATA_W = 128,
   parameter int TNEW_W = 4,
   parameter int A_W    = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [TNEW_W-1:0] in_tnew,
   input  logic [A_W-1:0]    in_a3,
   input  logic              in_reg_write,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TNEW_W-1:0] out_tnew,
   output logic [A_W-1:0]    out_a3,
   output logic              out_reg_write,
   output logic              skid_valid,
   output logic [A_W-1:0]    skid_a3,
   output logic [TNEW_W-1:0] skid_tnew,
   output logic [1:0]        occupancy
);
   logic [DATA_W-1:0] skid_data;
   logic              skid_reg_write;
   logic              accept;
   logic              main_free;

   function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
      return (x != '0) ? x - 1'b1 : '0;
   endfunction

   assign accept    = in_valid & in_ready;
   assign main_free = !out_valid | out_ready;
   assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

   // Invalid slots keep A3/Tnew/RegWrite at zero so hazard logic needs no valid gating.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_ready       <= 1'b1;
         out_valid      <= 1'b0;
         out_data       <= '0;
         out_tnew       <= '0;
         out_a3         <= '0;
         out_reg_write  <= 1'b0;
         skid_valid     <= 1'b0;
         skid_data      <= '0;
         skid_tnew      <= '0;
         skid_a3        <= '0;
         skid_reg_write <= 1'b0;
      end else if (flush) begin
         in_ready       <= 1'b1;
         out_valid      <= 1'b0;
         out_data       <= '0;
         out_tnew       <= '0;
         out_a3         <= '0;
         out_reg_write  <= 1'b0;
         skid_valid     <= 1'b0;
         skid_data      <= '0;
         skid_tnew      <= '0;
         skid_a3        <= '0;
         skid_reg_write <= 1'b0;
      end else if (main_free) begin
         in_ready <= 1'b1;
         if (skid_valid) begin
            out_valid      <= 1'b1;
            out_data       <= skid_data;
            out_tnew       <= sat_dec(skid_tnew);
            out_a3         <= skid_a3;
            out_reg_write  <= skid_reg_write;
            skid_valid     <= 1'b0;
            skid_data      <= '0;
            skid_tnew      <= '0;
            skid_a3        <= '0;
            skid_reg_write <= 1'b0;
         end else if (accept) begin
            out_valid     <= 1'b1;
            out_data      <= in_data;
            out_tnew      <= sat_dec(in_tnew);
            out_a3        <= in_a3;
            out_reg_write <= in_reg_write;
         end else begin
            // out_data is deliberately held; only the hazard fields are cleared.
            out_valid     <= 1'b0;
            out_tnew      <= '0;
            out_a3        <= '0;
            out_reg_write <= 1'b0;
         end
      end else begin
         out_tnew <= sat_dec(out_tnew);
         if (accept) begin
            in_ready       <= 1'b0;
            skid_valid     <= 1'b1;
            skid_data      <= in_data;
            skid_tnew      <= sat_dec(in_tnew);
            skid_a3        <= in_a3;
            skid_reg_write <= in_reg_write;
         end else begin
            skid_tnew <= sat_dec(skid_tnew);
         end
      end
   end
endmodule
